// File: rtl/bpred_update_queue_if.sv
// Branch-predictor update queue bus: Memory-stage retire input, table write
// port, Fetch-side forwarding lookup, and status.
interface bpred_update_queue_if #(
  parameter int XLEN  = 64,
  parameter int DROPW = 16
);
  logic             UpdValidM;
  logic [XLEN-1:0]  PCM;
  logic [XLEN-1:0]  IEUAdrM;
  logic             PCSrcM;
  logic [3:0]       IClassM;
  logic             FlushAll;
  logic             WrReady;
  logic             WrValid;
  logic [XLEN-1:0]  WrPC;
  logic [XLEN-1:0]  WrTarget;
  logic             WrTaken;
  logic [3:0]       WrIClass;
  logic [XLEN-1:0]  PCF;
  logic             PendHitF;
  logic [XLEN-1:0]  PendTargetF;
  logic             PendTakenF;
  logic             Full;
  logic [DROPW-1:0] DropCount;

  modport master (
    output UpdValidM, PCM, IEUAdrM, PCSrcM, IClassM, FlushAll, WrReady, PCF,
    input  WrValid, WrPC, WrTarget, WrTaken, WrIClass,
           PendHitF, PendTargetF, PendTakenF, Full, DropCount
  );

  modport slave (
    input  UpdValidM, PCM, IEUAdrM, PCSrcM, IClassM, FlushAll, WrReady, PCF,
    output WrValid, WrPC, WrTarget, WrTaken, WrIClass,
           PendHitF, PendTargetF, PendTakenF, Full, DropCount
  );
endinterface

// File: rtl/bpred_update_queue.sv
// Circular FIFO of resolved CFI outcomes draining into the predictor table
// write port, with coalescing on the youngest entry and a Fetch forwarding lookup.
module bpred_update_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int DROPW = 16
) (
  input  logic clk,
  input  logic reset,
  bpred_update_queue_if.slave u
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            tkn;
    logic [3:0]      cls;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;

  logic [AW-1:0] head_idx, tail_idx, yng_idx, lk_idx;
  logic          empty, full, deq, cfi, coal, enq, drop;
  logic          hit;
  logic [XLEN-1:0] hit_tgt;
  logic          hit_tkn;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign yng_idx  = tail_idx - AW'(1);
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
  assign deq      = ~empty & u.WrReady;
  assign cfi      = u.UpdValidM & (|u.IClassM) & ~u.FlushAll;
  // Coalescing into an entry that is leaving this cycle would lose the update.
  assign coal     = cfi & ~empty & (ent_q[yng_idx].pc == u.PCM)
                  & ~(deq & (yng_idx == head_idx));
  assign enq      = cfi & ~coal & (~full | deq);
  assign drop     = cfi & ~coal & full & ~deq;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    // Dequeue clears first so a full-with-dequeue enqueue can reuse the slot.
    if (deq) begin
      ent_d[head_idx].vld = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (coal) begin
      ent_d[yng_idx].tgt = u.IEUAdrM;
      ent_d[yng_idx].tkn = u.PCSrcM;
      ent_d[yng_idx].cls = u.IClassM;
    end
    if (enq) begin
      ent_d[tail_idx] = '{vld: 1'b1, pc: u.PCM, tgt: u.IEUAdrM,
                          tkn: u.PCSrcM, cls: u.IClassM};
      tail_d = tail_q + PW'(1);
    end
    if (drop && (drop_cnt_q != {DROPW{1'b1}})) drop_cnt_d = drop_cnt_q + DROPW'(1);
    if (u.FlushAll) begin
      head_d = '0;
      tail_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_tgt = '0;
    hit_tkn = 1'b0;
    lk_idx  = head_idx;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_idx + AW'(k);
      if (ent_q[lk_idx].vld && (ent_q[lk_idx].pc == u.PCF)) begin
        hit     = 1'b1;
        hit_tgt = ent_q[lk_idx].tgt;
        hit_tkn = ent_q[lk_idx].tkn;
      end
    end
  end

  assign u.WrValid     = ~empty;
  assign u.WrPC        = empty ? '0 : ent_q[head_idx].pc;
  assign u.WrTarget    = empty ? '0 : ent_q[head_idx].tgt;
  assign u.WrTaken     = ~empty & ent_q[head_idx].tkn;
  assign u.WrIClass    = empty ? 4'b0 : ent_q[head_idx].cls;
  assign u.PendHitF    = hit;
  assign u.PendTargetF = hit_tgt;
  assign u.PendTakenF  = hit_tkn;
  assign u.Full        = full;
  assign u.DropCount   = drop_cnt_q;
endmodule

// File: tb/tb_bpred_update_queue.sv
// Directed bench for bpred_update_queue: reset, overflow/saturation, full
// bypass, coalescing, lookup priority, wrap and flush.
module tb_bpred_update_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bpred_update_queue_if #(.XLEN(64), .DROPW(16)) bif ();
  bpred_update_queue_if #(.XLEN(64), .DROPW(2))  bif2 ();

  bpred_update_queue #(.XLEN(64), .DEPTH(8), .DROPW(16)) dut (
    .clk(clk), .reset(rst_n), .u(bif.slave));
  bpred_update_queue #(.XLEN(64), .DEPTH(8), .DROPW(2)) dut2 (
    .clk(clk), .reset(rst_n), .u(bif2.slave));

  // Second instance mirrors the stimulus; only its narrow drop counter is checked.
  assign bif2.UpdValidM = bif.UpdValidM;
  assign bif2.PCM       = bif.PCM;
  assign bif2.IEUAdrM   = bif.IEUAdrM;
  assign bif2.PCSrcM    = bif.PCSrcM;
  assign bif2.IClassM   = bif.IClassM;
  assign bif2.FlushAll  = bif.FlushAll;
  assign bif2.WrReady   = bif.WrReady;
  assign bif2.PCF       = bif.PCF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] tgt,
                      input logic tk, input logic [3:0] cl);
    bif.UpdValidM = 1'b1;
    bif.PCM       = pc;
    bif.IEUAdrM   = tgt;
    bif.PCSrcM    = tk;
    bif.IClassM   = cl;
  endtask

  task automatic nopush();
    bif.UpdValidM = 1'b0;
    bif.PCM       = '0;
    bif.IEUAdrM   = '0;
    bif.PCSrcM    = 1'b0;
    bif.IClassM   = 4'b0;
  endtask

  logic [63:0] exp_pc [8];

  initial begin
    nopush();
    bif.FlushAll = 1'b0;
    bif.WrReady  = 1'b0;
    bif.PCF      = 64'h10;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-traffic with three entries queued
    for (int i = 0; i < 3; i++) begin
      push(64'h10 + 64'(i * 4), 64'h50, 1'b1, 4'b0001);
      tick();
    end
    nopush();
    settle();
    chk("pre_rst_valid", bif.WrValid, 1);
    chk("pre_rst_hit", bif.PendHitF, 1);
    rst_n = 1'b0;
    settle();
    chk("rst_wrvalid", bif.WrValid, 0);
    chk("rst_wrpc", bif.WrPC, 0);
    chk("rst_wrtarget", bif.WrTarget, 0);
    chk("rst_hit", bif.PendHitF, 0);
    chk("rst_ptarget", bif.PendTargetF, 0);
    chk("rst_full", bif.Full, 0);
    chk("rst_drop", bif.DropCount, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic enqueue latency
    push(64'h1000, 64'h2000, 1'b1, 4'b0001);
    settle();
    chk("enq_c0_valid", bif.WrValid, 0);
    tick();
    nopush();
    settle();
    chk("enq_c1_valid", bif.WrValid, 1);
    chk("enq_c1_pc", bif.WrPC, 64'h1000);
    chk("enq_c1_tgt", bif.WrTarget, 64'h2000);
    chk("enq_c1_tkn", bif.WrTaken, 1);
    chk("enq_c1_cls", bif.WrIClass, 4'b0001);
    bif.WrReady = 1'b1;
    tick();
    bif.WrReady = 1'b0;
    settle();
    chk("enq_drained", bif.WrValid, 0);

    // Non-CFI is ignored
    push(64'h77, 64'h88, 1'b0, 4'b0000);
    tick();
    nopush();
    settle();
    chk("noncfi_valid", bif.WrValid, 0);

    // Overflow: 10 distinct enqueues into 8 slots, no drain
    for (int i = 1; i <= 10; i++) begin
      push(64'(i), 64'h100 + 64'(i), 1'b1, 4'b0001);
      tick();
      if (i == 7) chk("ovf_full7", bif.Full, 0);
      if (i == 8) chk("ovf_full8", bif.Full, 1);
    end
    nopush();
    settle();
    chk("ovf_drop", bif.DropCount, 2);
    chk("ovf_drop_w2", bif2.DropCount, 2);
    for (int i = 11; i <= 13; i++) begin
      push(64'(i), 64'h100 + 64'(i), 1'b0, 4'b0001);
      tick();
    end
    nopush();
    settle();
    chk("ovf_drop5", bif.DropCount, 5);
    chk("ovf_sat_w2", bif2.DropCount, 3);
    bif.WrReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk("drain_pc", bif.WrPC, 64'(k));
      chk("drain_tgt", bif.WrTarget, 64'h100 + 64'(k));
      tick();
    end
    bif.WrReady = 1'b0;
    settle();
    chk("drain_empty", bif.WrValid, 0);

    // Full with simultaneous enqueue and dequeue
    for (int i = 0; i < 8; i++) begin
      push(64'h21 + 64'(i), 64'h900, 1'b0, 4'b0010);
      tick();
    end
    nopush();
    settle();
    chk("bypass_full0", bif.Full, 1);
    push(64'h29, 64'h929, 1'b1, 4'b0100);
    bif.WrReady = 1'b1;
    settle();
    chk("bypass_head", bif.WrPC, 64'h21);
    tick();
    nopush();
    bif.WrReady = 1'b0;
    settle();
    chk("bypass_full1", bif.Full, 1);
    chk("bypass_drop", bif.DropCount, 5);
    for (int k = 0; k < 8; k++) exp_pc[k] = 64'h22 + 64'(k);
    bif.WrReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("bypass_order", bif.WrPC, exp_pc[k]);
      tick();
    end
    bif.WrReady = 1'b0;
    settle();
    chk("bypass_empty", bif.WrValid, 0);

    // Coalesce into youngest entry
    push(64'h40, 64'h80, 1'b0, 4'b0001);
    tick();
    push(64'h40, 64'h90, 1'b1, 4'b0001);
    tick();
    nopush();
    settle();
    chk("coal_tgt", bif.WrTarget, 64'h90);
    chk("coal_tkn", bif.WrTaken, 1);
    bif.WrReady = 1'b1;
    tick();
    settle();
    chk("coal_occ1", bif.WrValid, 0);

    // Sole entry leaving the same cycle: no coalesce
    bif.WrReady = 1'b0;
    push(64'h40, 64'h80, 1'b0, 4'b0001);
    tick();
    push(64'h40, 64'h90, 1'b1, 4'b0001);
    bif.WrReady = 1'b1;
    settle();
    chk("nocoal_first", bif.WrTarget, 64'h80);
    tick();
    nopush();
    settle();
    chk("nocoal_valid", bif.WrValid, 1);
    chk("nocoal_second", bif.WrTarget, 64'h90);
    tick();
    bif.WrReady = 1'b0;
    settle();
    chk("nocoal_empty", bif.WrValid, 0);

    // Lookup priority: youngest match wins
    push(64'h40, 64'h80, 1'b0, 4'b0001);
    tick();
    push(64'h44, 64'h84, 1'b0, 4'b0001);
    tick();
    push(64'h40, 64'hA0, 1'b1, 4'b0001);
    tick();
    nopush();
    bif.PCF = 64'h40;
    settle();
    chk("lk_hit", bif.PendHitF, 1);
    chk("lk_tgt", bif.PendTargetF, 64'hA0);
    chk("lk_tkn", bif.PendTakenF, 1);
    bif.PCF = 64'h44;
    settle();
    chk("lk_mid_tgt", bif.PendTargetF, 64'h84);
    bif.PCF = 64'h48;
    settle();
    chk("lk_miss", bif.PendHitF, 0);
    chk("lk_miss_tgt", bif.PendTargetF, 0);
    push(64'h48, 64'hC8, 1'b0, 4'b1000);
    settle();
    chk("lk_same_cyc", bif.PendHitF, 0);
    tick();
    nopush();
    settle();
    chk("lk_next_cyc", bif.PendHitF, 1);
    chk("lk_next_tgt", bif.PendTargetF, 64'hC8);
    bif.FlushAll = 1'b1;
    tick();
    bif.FlushAll = 1'b0;
    settle();
    chk("lk_flushed", bif.WrValid, 0);

    // Wrap pointers with occupancy one, then flush a three-entry queue
    bif.WrReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(64'h300 + 64'(i * 4), 64'h700 + 64'(i), 1'b0, 4'b0001);
      tick();
      chk("wrap_pc", bif.WrPC, 64'h300 + 64'(i * 4));
    end
    bif.WrReady = 1'b0;
    push(64'h400, 64'h800, 1'b0, 4'b0001);
    tick();
    push(64'h404, 64'h804, 1'b0, 4'b0001);
    tick();
    settle();
    chk("wrap_head", bif.WrPC, 64'h34C);
    push(64'h500, 64'h900, 1'b1, 4'b0001);
    bif.FlushAll = 1'b1;
    bif.WrReady  = 1'b1;
    bif.PCF      = 64'h500;
    tick();
    nopush();
    bif.FlushAll = 1'b0;
    bif.WrReady  = 1'b0;
    settle();
    chk("flush_valid", bif.WrValid, 0);
    chk("flush_full", bif.Full, 0);
    chk("flush_hit", bif.PendHitF, 0);
    chk("flush_drop", bif.DropCount, 5);
    tick(); tick();
    chk("flush_gone", bif.WrValid, 0);
    push(64'h600, 64'hA00, 1'b0, 4'b0010);
    tick();
    nopush();
    settle();
    chk("post_flush_pc", bif.WrPC, 64'h600);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
